// File: rtl/base_aroute_pkg.sv
// Shared types and helpers for the base_aroute_demux packet router.
package base_aroute_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } state_t;

  // Index bits needed to address n ways, never less than 1.
  function automatic int clog2_min1(input int n);
    for (int r = 1; r < 31; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/base_aburp_latch.sv
// Two-entry skid buffer: ready comes only from registered occupancy, output from the head entry.
module base_aburp_latch #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d
);

  logic [width-1:0] mem_reg [0:1];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             push;
  logic             pop;

  assign i_r  = (count_reg != 2'd2);
  assign o_v  = (count_reg != 2'd0);
  assign o_d  = mem_reg[rd_ptr_reg];
  assign push = i_v & i_r;
  assign pop  = o_v & o_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= i_d;
  end

endmodule

// File: rtl/base_aroute_demux.sv
// Packet demultiplexer: routes whole packets to one of `ways` skid-buffered outputs.
// Optional out-of-range detection/drop enabled by macro BASE_AROUTE_DEMUX_CHECK_EN.
module base_aroute_demux
  import base_aroute_pkg::*;
#(
  parameter int width     = 1,
  parameter int ways      = 2,
  parameter int dst_width = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   i_r,
  input  logic                   i_v,
  input  logic                   i_h,
  input  logic [dst_width-1:0]   i_dst,
  input  logic [width-1:0]       i_d,
  input  logic [0:ways-1]        o_r,
  output logic [0:ways-1]        o_v,
  output logic [0:ways-1]        o_h,
  output logic [0:(ways*width)-1] o_d,
  output logic                   o_err
);

`ifdef BASE_AROUTE_DEMUX_CHECK_EN
  localparam bit check_en = 1'b1;
`else
  localparam bit check_en = 1'b0;
`endif

  localparam int                   sel_width = clog2_min1(ways);
  localparam logic [dst_width-1:0] last_way  = dst_width'(ways - 1);

  if (ways < 1 || ways > 64 || dst_width < sel_width) begin : g_bad_cfg
    $error("base_aroute_demux: illegal ways/dst_width combination");
  end

  state_t                 state_reg, state_next;
  logic [sel_width-1:0]   dst_reg, dst_next;
  logic                   err_reg, err_next;
  logic [sel_width-1:0]   sel;
  logic                   discard;
  logic                   sel_ready;
  logic                   out_of_range;
  logic                   accept;
  logic [0:ways-1]        buf_iv;
  logic [0:ways-1]        buf_ir;

  // A single way has nothing to choose, so i_dst is never out of range.
  assign out_of_range = (ways > 1) && (i_dst > last_way);
  assign accept       = i_v & i_r;
  assign o_err        = check_en & err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      dst_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dst_reg   <= dst_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    sel        = '0;
    discard    = 1'b0;
    sel_ready  = 1'b0;
    state_next = state_reg;
    dst_next   = dst_reg;
    err_next   = err_reg;

    case (state_reg)
      LOCK:    sel = dst_reg;
      DROP:    discard = 1'b1;
      default: begin
        if (ways > 1) sel = out_of_range ? sel_width'(ways - 1) : i_dst[sel_width-1:0];
        discard = check_en & out_of_range;
      end
    endcase

    for (int k = 0; k < ways; k++) begin
      if (sel == sel_width'(k)) sel_ready = buf_ir[k];
    end
    i_r = reset & (discard | sel_ready);

    if (accept) begin
      if (!i_h) begin
        state_next = IDLE;
      end else if (state_reg == IDLE) begin
        state_next = discard ? DROP : LOCK;
        dst_next   = sel;
      end
      if (state_reg == IDLE && discard) err_next = 1'b1;
    end
  end

  for (genvar gi = 0; gi < ways; gi++) begin : g_way
    logic [width:0] buf_d;

    assign buf_iv[gi] = i_v & ~discard & (sel == sel_width'(gi));

    base_aburp_latch #(.width(width + 1)) u_buf (
      .clk   (clk),
      .reset (reset),
      .i_v   (buf_iv[gi]),
      .i_r   (buf_ir[gi]),
      .i_d   ({i_h, i_d}),
      .o_v   (o_v[gi]),
      .o_r   (o_r[gi]),
      .o_d   (buf_d)
    );

    assign o_h[gi]                = buf_d[width];
    assign o_d[gi*width +: width] = buf_d[width-1:0];
  end

endmodule

// File: tb/tb_base_aroute_demux.sv
// Randomized and directed bench for base_aroute_demux (ways=4, width=8, 3-bit destination).
module tb_base_aroute_demux;

`ifdef BASE_AROUTE_DEMUX_CHECK_EN
  localparam bit check_en = 1'b1;
`else
  localparam bit check_en = 1'b0;
`endif

  localparam int WAYS = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_r;
  logic              i_v;
  logic              i_h;
  logic [2:0]        i_dst;
  logic [W-1:0]      i_d;
  logic [0:WAYS-1]   o_r;
  logic [0:WAYS-1]   o_v;
  logic [0:WAYS-1]   o_h;
  logic [0:WAYS*W-1] o_d;
  logic              o_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one queue of {h,d} per way, plus the packet in progress.
  logic [W:0] mq [0:WAYS-1][$];
  int         m_lock = -1;   // -1 idle, 0..3 locked way, 4 dropping
  bit         m_err  = 1'b0;

  always #5 clk = ~clk;

  base_aroute_demux #(.width(W), .ways(WAYS), .dst_width(3)) dut (
    .clk   (clk),
    .reset (reset),
    .i_r   (i_r),
    .i_v   (i_v),
    .i_h   (i_h),
    .i_dst (i_dst),
    .i_d   (i_d),
    .o_r   (o_r),
    .o_v   (o_v),
    .o_h   (o_h),
    .o_d   (o_d),
    .o_err (o_err)
  );

  task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Way that a beat goes to under the current model state; -1 means discarded.
  function automatic int route(logic [2:0] dst);
    if (m_lock == 4) return -1;
    if (m_lock >= 0) return m_lock;
    if (dst >= 3'(WAYS)) return check_en ? -1 : WAYS - 1;
    return int'(dst);
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input bit v, input bit h, input logic [2:0] dst,
                      input logic [W-1:0] d, input logic [0:WAYS-1] ordy, output bit acc);
    int              tgt;
    bit              exp_ir;
    logic [0:WAYS-1] ev;
    i_v = v; i_h = h; i_dst = dst; i_d = d; o_r = ordy;
    #1;
    tgt    = route(dst);
    exp_ir = (tgt < 0) ? 1'b1 : (mq[tgt].size() < 2);
    check_val("i_r", i_r, exp_ir);
    for (int k = 0; k < WAYS; k++) begin
      ev[k] = (mq[k].size() != 0);
      if (ev[k]) check_val($sformatf("o_hd%0d", k), {o_h[k], o_d[k*W +: W]}, mq[k][0]);
    end
    check_val("o_v", o_v, ev);
    check_val("o_err", o_err, m_err);
    acc = v & exp_ir;
    @(posedge clk);
    for (int k = 0; k < WAYS; k++)
      if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
    if (acc) begin
      if (tgt >= 0) mq[tgt].push_back({h, d});
      if (m_lock == -1 && dst >= 3'(WAYS) && check_en) m_err = 1'b1;
      if (!h)               m_lock = -1;
      else if (m_lock == -1) m_lock = (tgt < 0) ? 4 : tgt;
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input bit h, input logic [2:0] dst, input logic [W-1:0] d,
                           input logic [0:WAYS-1] ordy);
    bit acc = 1'b0;
    for (int n = 0; n < 32 && !acc; n++) tick(1'b1, h, dst, d, ordy, acc);
    check_val("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Asserts reset between clock edges, checks the reset view, releases on the next falling edge.
  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    check_val("rst_i_r", i_r, 1'b0);
    check_val("rst_o_v", o_v, '0);
    check_val("rst_o_err", o_err, 1'b0);
    for (int k = 0; k < WAYS; k++) mq[k].delete();
    m_lock = -1;
    m_err  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    i_v   = 1'b0;
    i_dst = '0;
    #1;
    check_val("i_r_after_reset", i_r, 1'b1);
  endtask

  task automatic idle_cycles(input int n, input logic [0:WAYS-1] ordy);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, '0, ordy, acc);
  endtask

  initial begin
    bit acc;
    reset = 1'b0; i_v = 1'b0; i_h = 1'b0; i_dst = '0; i_d = '0; o_r = '1;
    @(negedge clk);
    reset_pulse();

    // Single beats to each way on consecutive cycles.
    send_beat(1'b0, 3'd0, 8'h11, 4'b1111);
    send_beat(1'b0, 3'd1, 8'h22, 4'b1111);
    send_beat(1'b0, 3'd2, 8'h33, 4'b1111);
    send_beat(1'b0, 3'd3, 8'h44, 4'b1111);
    idle_cycles(2, 4'b1111);

    // Locked packet ignores i_dst after its first beat.
    send_beat(1'b1, 3'd2, 8'hA1, 4'b1111);
    send_beat(1'b1, 3'd0, 8'hA2, 4'b1111);
    send_beat(1'b0, 3'd0, 8'hA3, 4'b1111);
    send_beat(1'b0, 3'd0, 8'hA4, 4'b1111);
    idle_cycles(2, 4'b1111);

    // Stalled way 1: two beats fill it, the third waits until it drains.
    send_beat(1'b1, 3'd1, 8'hB1, 4'b1011);
    send_beat(1'b1, 3'd1, 8'hB2, 4'b1011);
    tick(1'b1, 1'b1, 3'd3, 8'hB3, 4'b1011, acc);
    tick(1'b1, 1'b1, 3'd3, 8'hB3, 4'b1011, acc);
    check_val("stall_hold", 64'(acc), 64'd0);
    send_beat(1'b1, 3'd3, 8'hB3, 4'b1111);
    send_beat(1'b1, 3'd3, 8'hB4, 4'b1111);
    send_beat(1'b0, 3'd3, 8'hB5, 4'b1111);
    idle_cycles(3, 4'b1111);

    // A stalled way does not block a new packet to another way.
    send_beat(1'b0, 3'd1, 8'hC1, 4'b1011);
    send_beat(1'b0, 3'd1, 8'hC2, 4'b1011);
    send_beat(1'b0, 3'd3, 8'hC3, 4'b1011);
    idle_cycles(3, 4'b1111);

    // Out-of-range two-beat packet: dropped with error, or clamped to the last way.
    send_beat(1'b1, 3'd5, 8'hD1, 4'b1111);
    send_beat(1'b0, 3'd5, 8'hD2, 4'b1111);
    idle_cycles(3, 4'b1111);
    send_beat(1'b0, 3'd1, 8'hD3, 4'b1111);
    idle_cycles(2, 4'b1111);

    // Reset in the middle of a packet to way 0, then a fresh packet.
    send_beat(1'b1, 3'd0, 8'hE1, 4'b0111);
    i_v = 1'b1; i_h = 1'b1; i_dst = 3'd0; i_d = 8'hE2;
    reset_pulse();
    send_beat(1'b1, 3'd2, 8'hF1, 4'b1111);
    send_beat(1'b0, 3'd0, 8'hF2, 4'b1111);
    idle_cycles(2, 4'b1111);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [2:0]      dst;
      logic [0:WAYS-1] ordy;
      dst  = ($urandom_range(0, 5) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      ordy = 4'($urandom) | 4'($urandom);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, dst, 8'($urandom), ordy, acc);
      if (i % 150 == 149) reset_pulse();
    end
    idle_cycles(4, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
